// File: rtl/seq_vector_checker_if.sv
// Stimulus/response and status bundle between seq_vector_checker and its bench.
// The master side drives start and the DUT/golden responses; the slave side is the checker.
interface seq_vector_checker_if #(
    parameter int INBITS  = 4,
    parameter int OUTBITS = 4,
    parameter int ERRW    = 8
);
    logic                start;
    logic [INBITS-1:0]   comp_in;
    logic [OUTBITS-1:0]  verify;
    logic [OUTBITS-1:0]  comp_out;
    logic                busy;
    logic                done;
    logic                pass;
    logic [ERRW-1:0]     err_count;
    logic                fail_valid;
    logic [INBITS-1:0]   fail_vec;

    modport master (
        output start, verify, comp_out,
        input  comp_in, busy, done, pass, err_count, fail_valid, fail_vec
    );

    modport slave (
        input  start, verify, comp_out,
        output comp_in, busy, done, pass, err_count, fail_valid, fail_vec
    );
endinterface

// File: rtl/seq_vector_checker.sv
// Clocked exhaustive sweep: per vector GAP cycles of X, SETTLE cycles held, one CHECK edge; done one edge after the last check.
// start is honoured only when idle or done; SEQ_CHECK_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module seq_vector_checker #(
    parameter int INBITS  = 4,
    parameter int OUTBITS = 4,
    parameter int GAP     = 1,
    parameter int SETTLE  = 2,
    parameter int ERRW    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_vector_checker_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_GAP, S_SETTLE, S_CHECK, S_DONE} state_t;

    localparam logic [15:0]       GAP_LAST    = 16'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [15:0]       SETTLE_LAST = 16'((SETTLE > 1) ? SETTLE - 1 : 0);
    localparam logic [ERRW-1:0]   ERR_MAX     = '1;
    localparam logic [INBITS-1:0] VEC_LAST    = '1;

    state_t              state_q, state_d;
    logic [INBITS-1:0]   vec_q, vec_d;
    logic [15:0]         wait_q, wait_d;
    logic [INBITS-1:0]   comp_in_q, comp_in_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [ERRW-1:0]     err_q, err_d;
    logic                fail_valid_q, fail_valid_d;
    logic [INBITS-1:0]   fail_vec_q, fail_vec_d;
    logic                mismatch;
    logic                stop;

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        wait_d       = wait_q;
        comp_in_d    = comp_in_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_d        = err_q;
        fail_valid_d = fail_valid_q;
        fail_vec_d   = fail_vec_q;
        // Case inequality so an X/Z on either side is a mismatch, not a silent pass.
        mismatch     = (bus.comp_out !== bus.verify);
        stop         = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                // Status settles one edge after entering DONE, so done trails the last check by one cycle.
                if (state_q == S_DONE) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    pass_d = (err_q == '0);
                end
                if (bus.start && !busy_q) begin
                    vec_d        = '0;
                    wait_d       = '0;
                    err_d        = '0;
                    fail_valid_d = 1'b0;
                    fail_vec_d   = '0;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    busy_d       = 1'b1;
                    if (GAP > 0) begin
                        state_d   = S_GAP;
                        comp_in_d = {INBITS{1'bx}};
                    end else begin
                        state_d   = S_SETTLE;
                        comp_in_d = '0;
                    end
                end
            end
            S_GAP: begin
                if (wait_q == GAP_LAST) begin
                    state_d   = S_SETTLE;
                    wait_d    = '0;
                    comp_in_d = vec_q;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_SETTLE: begin
                if (wait_q == SETTLE_LAST) begin
                    state_d = S_CHECK;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (mismatch) begin
                    if (err_q != ERR_MAX) err_d = err_q + 1'b1;
                    if (!fail_valid_q) begin
                        fail_valid_d = 1'b1;
                        fail_vec_d   = vec_q;
                    end
                end
                stop = (vec_q == VEC_LAST);
`ifdef SEQ_CHECK_STOP_ON_FAIL_EN
                stop = stop || mismatch;
`endif
                if (stop) begin
                    state_d = S_DONE;
                end else begin
                    vec_d  = vec_q + 1'b1;
                    wait_d = '0;
                    if (GAP > 0) begin
                        state_d   = S_GAP;
                        comp_in_d = {INBITS{1'bx}};
                    end else begin
                        state_d   = S_SETTLE;
                        comp_in_d = vec_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            vec_q        <= '0;
            wait_q       <= '0;
            comp_in_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            wait_q       <= wait_d;
            comp_in_q    <= comp_in_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_q        <= err_d;
            fail_valid_q <= fail_valid_d;
            fail_vec_q   <= fail_vec_d;
        end
    end

    assign bus.comp_in    = comp_in_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_count  = err_q;
    assign bus.fail_valid = fail_valid_q;
    assign bus.fail_vec   = fail_vec_q;
endmodule

// File: tb/tb_seq_vector_checker.sv
// Scoreboard bench: two checker instances (2-bit sweep, 4-bit sweep with 2-bit error counter) against small DUT models.
module tb_seq_vector_checker;
`ifdef SEQ_CHECK_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    typedef struct {
        int         lat;
        logic       pass;
        logic [7:0] err;
        logic       fv;
        logic [3:0] vec;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    int   mode_a;
    bit   seq_chk;
    exp_t qa[$];
    exp_t qb[$];

    seq_vector_checker_if #(.INBITS(2), .OUTBITS(2), .ERRW(8)) a_if();
    seq_vector_checker_if #(.INBITS(4), .OUTBITS(4), .ERRW(2)) b_if();

    seq_vector_checker #(.INBITS(2), .OUTBITS(2), .GAP(1), .SETTLE(2), .ERRW(8)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(a_if));
    seq_vector_checker #(.INBITS(4), .OUTBITS(4), .GAP(1), .SETTLE(2), .ERRW(2)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(b_if));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mode 0 identity, 1 bit0 flipped on input 2, 2 bit0 flipped on input 1, 3 output 1x on input 0.
    always_comb begin
        a_if.verify   = a_if.comp_in;
        a_if.comp_out = a_if.comp_in;
        if (mode_a == 1 && a_if.comp_in === 2'd2) a_if.comp_out = a_if.comp_in ^ 2'b01;
        if (mode_a == 2 && a_if.comp_in === 2'd1) a_if.comp_out = a_if.comp_in ^ 2'b01;
        if (mode_a == 3 && a_if.comp_in === 2'd0) a_if.comp_out = 2'b1x;
    end

    always_comb begin
        b_if.verify   = b_if.comp_in;
        b_if.comp_out = 4'd0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(int lat, logic pass, logic [7:0] err, logic fv, logic [3:0] vec);
        exp_t e;
        e.lat = lat; e.pass = pass; e.err = err; e.fv = fv; e.vec = vec;
        return e;
    endfunction

    // Monitor A: latency counted from busy rising; result popped when done rises.
    initial begin : mon_a
        int   cnt;
        logic pb, pd;
        exp_t e;
        cnt = 0; pb = 1'b0; pd = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (a_if.busy && !pb) cnt = 0; else cnt++;
            if (seq_chk && a_if.busy && (cnt % 4) == 1) chk("a_seq_comp_in", 32'(a_if.comp_in), 32'(cnt / 4));
            if (a_if.done && !pd) begin
                if (qa.size() == 0) begin
                    chk("a_unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = qa.pop_front();
                    chk("a_latency",    32'(cnt),               32'(e.lat));
                    chk("a_pass",       32'(a_if.pass),         32'(e.pass));
                    chk("a_err_count",  32'(a_if.err_count),    32'(e.err));
                    chk("a_fail_valid", 32'(a_if.fail_valid),   32'(e.fv));
                    chk("a_fail_vec",   32'(a_if.fail_vec),     32'(e.vec));
                end
            end
            pb = a_if.busy; pd = a_if.done;
        end
    end

    initial begin : mon_b
        int   cnt;
        logic pb, pd;
        exp_t e;
        cnt = 0; pb = 1'b0; pd = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (b_if.busy && !pb) cnt = 0; else cnt++;
            if (b_if.done && !pd) begin
                if (qb.size() == 0) begin
                    chk("b_unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = qb.pop_front();
                    chk("b_latency",    32'(cnt),             32'(e.lat));
                    chk("b_pass",       32'(b_if.pass),       32'(e.pass));
                    chk("b_err_count",  32'(b_if.err_count),  32'(e.err[1:0]));
                    chk("b_fail_valid", 32'(b_if.fail_valid), 32'(e.fv));
                    chk("b_fail_vec",   32'(b_if.fail_vec),   32'(e.vec));
                end
            end
            pb = b_if.busy; pd = b_if.done;
        end
    end

    task automatic start_a(input bit push, input exp_t e);
        @(negedge clk);
        if (push) qa.push_back(e);
        a_if.start = 1'b1;
        @(negedge clk);
        a_if.start = 1'b0;
    endtask

    task automatic wait_done(input int which, input int maxc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < maxc && !seen; i++) begin
            @(posedge clk); #2;
            seen = (which == 0) ? a_if.done : b_if.done;
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_comp_in"},    32'(a_if.comp_in),    32'd0);
        chk({tag, "_busy"},       32'(a_if.busy),       32'd0);
        chk({tag, "_done"},       32'(a_if.done),       32'd0);
        chk({tag, "_pass"},       32'(a_if.pass),       32'd0);
        chk({tag, "_err_count"},  32'(a_if.err_count),  32'd0);
        chk({tag, "_fail_valid"}, 32'(a_if.fail_valid), 32'd0);
        chk({tag, "_fail_vec"},   32'(a_if.fail_vec),   32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation did not complete");
    end

    initial begin : stim
        tests = 0; fails = 0; mode_a = 0; seq_chk = 1'b0;
        a_if.start = 1'b0; b_if.start = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #12;
        chk_reset_a("rst");
        chk("rst_b_busy", 32'(b_if.busy), 32'd0);
        chk("rst_b_err",  32'(b_if.err_count), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Clean sweep, with a start pulse mid-sweep that must be ignored.
        mode_a = 0; seq_chk = 1'b1;
        start_a(1'b1, mk(17, 1'b1, 8'd0, 1'b0, 4'd0));
        repeat (5) @(negedge clk);
        a_if.start = 1'b1;
        @(negedge clk) a_if.start = 1'b0;
        wait_done(0, 40);
        seq_chk = 1'b0;

        // Single mismatch on input 2.
        mode_a = 1;
        start_a(1'b1, mk(STOP ? 13 : 17, 1'b0, 8'd1, 1'b1, 4'd2));
        wait_done(0, 40);
        chk("a_hold_comp_in_m1", 32'(a_if.comp_in), STOP ? 32'd2 : 32'd3);

        // X on the DUT output for input 0.
        mode_a = 3;
        start_a(1'b1, mk(STOP ? 5 : 17, 1'b0, 8'd1, 1'b1, 4'd0));
        wait_done(0, 40);

        // Mismatch on input 1, then restart from DONE with a clean DUT.
        mode_a = 2;
        start_a(1'b1, mk(STOP ? 9 : 17, 1'b0, 8'd1, 1'b1, 4'd1));
        wait_done(0, 40);
        chk("a_hold_comp_in_m2", 32'(a_if.comp_in), STOP ? 32'd1 : 32'd3);
        mode_a = 0;
        start_a(1'b1, mk(17, 1'b1, 8'd0, 1'b0, 4'd0));
        chk("a_done_drops", 32'(a_if.done), 32'd0);
        wait_done(0, 40);

        // Reset during SETTLE of vector 2, then a fresh sweep from vector 0.
        start_a(1'b0, mk(0, 1'b0, 8'd0, 1'b0, 4'd0));
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_a("mid_rst");
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        seq_chk = 1'b1;
        start_a(1'b1, mk(17, 1'b1, 8'd0, 1'b0, 4'd0));
        wait_done(0, 40);
        seq_chk = 1'b0;

        // Constant-zero DUT on a 4-bit sweep; 2-bit counter saturates at 3.
        @(negedge clk);
        qb.push_back(mk(STOP ? 9 : 65, 1'b0, STOP ? 8'd1 : 8'd3, 1'b1, 4'd1));
        b_if.start = 1'b1;
        @(negedge clk) b_if.start = 1'b0;
        wait_done(1, 120);

        repeat (3) @(negedge clk);
        chk("a_queue_empty", 32'(qa.size()), 32'd0);
        chk("b_queue_empty", 32'(qb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
